// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM.
//
// Contents:
//   state_t - controller states; S_TRAP exists only when MIPS_MC_ILLEGAL_TRAP_EN is defined
//   OP_*    - opcode constants taken from Instruction[31:26]
//   ALU_*   - alu_op encodings consumed by the ALU-control decoder
//   SRCB_*  - alu_src_b mux encodings
//   PCSRC_* - pc_source mux encodings
//   ctrl_t  - bundle of every control output the FSM drives
//
// Optional feature macro: MIPS_MC_ILLEGAL_TRAP_EN
package mips_mc_pkg;

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB,
    S_MEM_WRITE, S_R_EXEC, S_R_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;
`else
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB,
    S_MEM_WRITE, S_R_EXEC, S_R_WB, S_BRANCH, S_JUMP
  } state_t;
`endif

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the main control FSM and the multicycle datapath.
//
// Signals:
//   opcode, mem_ready         - datapath/memory -> controller
//   pc_write .. pc_source     - controller -> datapath mux selects and enables
//   instr_done, instr_count   - retirement pulse and wrapping retired count
//   illegal_op                - trap flag (only ever set with MIPS_MC_ILLEGAL_TRAP_EN)
// Modports: master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic             illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, instr_count, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, instr_count, illegal_op
  );
endinterface

// File: rtl/mips_mc_out_decode.sv
// Combinational Moore output decode for the multicycle MIPS controller.
//
// Ports:
//   state     in  current FSM state
//   mem_ready in  memory handshake (only affects ir_write/pc_write in FETCH)
//   rst       in  forces every control output to 0 while asserted
//   ctrl      out decoded control bundle
//
// Optional feature macro: MIPS_MC_ILLEGAL_TRAP_EN (adds the TRAP decode).
module mips_mc_out_decode
  import mips_mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   rst,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only load on the cycle the instruction word arrives.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // PC + (imm << 2) is computed speculatively for a possible beq.
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      S_TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
    if (rst) begin
      ctrl = '0;
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath (R-type, lw, sw, beq, j).
// Holds the state register, next-state logic and the retired-instruction
// counter; control outputs come from mips_mc_out_decode.
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  master modport of mips_multicycle_ctrl_if (opcode/mem_ready in,
//        control outputs, instr_done, instr_count, illegal_op out)
// Parameters:
//   CNT_W  width of the wrapping retired-instruction counter
//
// Optional feature macro: MIPS_MC_ILLEGAL_TRAP_EN
//   defined   - unknown opcodes park the FSM in TRAP with illegal_op=1 until rst
//   undefined - unknown opcodes retire as a two-cycle NOP, illegal_op tied 0
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                    clk,
  input logic                    rst,
  mips_multicycle_ctrl_if.master bus
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic             done;
  ctrl_t            ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (done) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (bus.mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_R:         state_next = S_R_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            state_next = S_TRAP;
`else
            state_next = S_FETCH;
            done       = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_ADDR: state_next = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (bus.mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        state_next = S_FETCH;
        done       = 1'b1;
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready) begin
          state_next = S_FETCH;
          done       = 1'b1;
        end
      end
      S_R_EXEC: state_next = S_R_WB;
      S_R_WB, S_BRANCH, S_JUMP: begin
        state_next = S_FETCH;
        done       = 1'b1;
      end
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      S_TRAP: state_next = S_TRAP;
`endif
      default: state_next = S_FETCH;
    endcase
    // An instruction cut short by reset never retires.
    if (rst) begin
      done = 1'b0;
    end
  end

  mips_mc_out_decode u_out_decode (
    .state     (state_reg),
    .mem_ready (bus.mem_ready),
    .rst       (rst),
    .ctrl      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.instr_done    = done;
  assign bus.instr_count   = count_reg;

endmodule
